// File: rtl/mod_mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine with a bypass mode.
// A full state is accepted over valid/ready, COLS_PER_CYCLE columns are
// transformed per clock, and the result is held until the consumer takes it.
module mod_mixcolumns_iter #(
    parameter int unsigned NB_COLS        = 4,
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NB_COLS*4-1:0][7:0]    in_state,
    input  logic [1:0]                   in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NB_COLS*4-1:0][7:0]    out_state,
    output logic                         busy
);

    localparam int unsigned NGRP  = NB_COLS / COLS_PER_CYCLE;
    localparam int unsigned CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned COL_W = $clog2(NB_COLS);

    // Column c occupies bits [c*32 +: 32], row r is byte r of that word.
    typedef logic [NB_COLS-1:0][3:0][7:0] state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    // Reject illegal configurations at elaboration time.
    if (NB_COLS < 4 || NB_COLS > 8) begin : g_bad_nb_cols
        $error("mod_mixcolumns_iter: NB_COLS must be in 4..8");
    end
    if (COLS_PER_CYCLE == 0 || (NB_COLS % COLS_PER_CYCLE) != 0) begin : g_bad_cpc
        $error("mod_mixcolumns_iter: COLS_PER_CYCLE must divide NB_COLS");
    end

    fsm_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    state_t           work_q,  work_d;
    state_t           out_q,   out_d;
    logic [1:0]       mode_q,  mode_d;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of MixColumns (inv=0) or InvMixColumns (inv=1).
    function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] a, input logic inv);
        logic [3:0][7:0] x2, x4, x8, m2, m3, m9, mb, md, me, b;
        for (int unsigned r = 0; r < 4; r++) begin
            x2[r] = xt(a[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
            m2[r] = x2[r];
            m3[r] = x2[r] ^ a[r];
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        if (!inv) begin
            b[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
            b[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
            b[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
            b[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
        end else begin
            b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return b;
    endfunction

    // State, counter, working and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: accept, iterate over column groups, hold result.
    always_comb begin
        logic             load;
        logic [COL_W-1:0] idx;
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        out_d    = out_q;
        mode_d   = mode_q;
        load     = 1'b0;
        idx      = '0;
        in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);

        unique case (state_q)
            S_IDLE: begin
                load = in_valid;
            end
            S_BUSY: begin
                // Bypass still walks the groups so timing matches the transforms.
                for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
                    idx = COL_W'(32'(cnt_q) * COLS_PER_CYCLE + i);
                    if (!mode_q[1]) begin
                        work_d[idx] = mix_col(work_q[idx], mode_q[0]);
                    end
                end
                if (cnt_q == CNT_W'(NGRP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    out_d   = work_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    load    = in_valid;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            work_d  = in_state;
            mode_d  = in_mode;
            cnt_d   = '0;
            state_d = S_BUSY;
        end
    end

    assign out_state = out_q;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);

endmodule

// File: tb/tb_mod_mixcolumns_iter.sv
// Directed bench for mod_mixcolumns_iter: transforms, bypass, latency,
// backpressure, parameter sweep and asynchronous reset.
module tb_mod_mixcolumns_iter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid, out_ready, in_ready, out_valid, busy;
    logic [1:0]   in_mode;
    logic [127:0] in_state, out_state;

    logic         sw_valid, sw_ready;
    logic [1:0]   sw_mode;
    logic [127:0] sw4, o1, o2;
    logic [255:0] sw8, o3;
    logic         r1, r2, r3, v1, v2, v3, b1, b2, b3;

    int errors = 0;
    int checks = 0;
    int n, l1, l2, l3;
    logic [127:0] exp4, held;

    always #5 clk = ~clk;

    mod_mixcolumns_iter #(.NB_COLS(4), .COLS_PER_CYCLE(1)) u0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .busy(busy));

    mod_mixcolumns_iter #(.NB_COLS(4), .COLS_PER_CYCLE(2)) u1 (
        .clk(clk), .resetn(resetn), .in_valid(sw_valid), .in_ready(r1),
        .in_state(sw4), .in_mode(sw_mode), .out_valid(v1),
        .out_ready(sw_ready), .out_state(o1), .busy(b1));

    mod_mixcolumns_iter #(.NB_COLS(4), .COLS_PER_CYCLE(4)) u2 (
        .clk(clk), .resetn(resetn), .in_valid(sw_valid), .in_ready(r2),
        .in_state(sw4), .in_mode(sw_mode), .out_valid(v2),
        .out_ready(sw_ready), .out_state(o2), .busy(b2));

    mod_mixcolumns_iter #(.NB_COLS(8), .COLS_PER_CYCLE(4)) u3 (
        .clk(clk), .resetn(resetn), .in_valid(sw_valid), .in_ready(r3),
        .in_state(sw8), .in_mode(sw_mode), .out_valid(v3),
        .out_ready(sw_ready), .out_state(o3), .busy(b3));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Column written as a0a1a2a3 in reading order; a0 lands in the low byte.
    function automatic logic [31:0] col(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] st4(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
        return {col(c3), col(c2), col(c1), col(c0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'b00; in_state = '0;
        sw_valid = 1'b0; sw_ready = 1'b0; sw_mode = 2'b00; sw4 = '0; sw8 = '0;
        #12;
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_busy",      256'(busy),      256'(1'b0));
        chk("rst_in_ready",  256'(in_ready),  256'(1'b1));
        chk("rst_out_state", 256'(out_state), 256'(0));
        resetn = 1'b1;
        tick();

        // Forward; in_mode changed while busy must be ignored.
        in_state = st4(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
        in_mode  = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_mode  = 2'b01;
        chk("fwd_busy",     256'(busy),     256'(1'b1));
        chk("fwd_in_ready", 256'(in_ready), 256'(1'b0));
        wait_done(n);
        chk("fwd_latency", 256'(n), 256'(4));
        chk("fwd_state", 256'(out_state),
            256'(st4(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc)));
        consume();
        chk("fwd_released", 256'(out_valid), 256'(1'b0));

        // Inverse.
        in_state = st4(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);
        in_mode  = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(n);
        chk("inv_latency", 256'(n), 256'(4));
        chk("inv_state", 256'(out_state),
            256'(st4(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5)));
        consume();

        // Bypass, mode 10.
        in_state = st4(32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d);
        in_mode  = 2'b10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(n);
        chk("byp10_latency", 256'(n), 256'(4));
        chk("byp10_state", 256'(out_state),
            256'(st4(32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d)));
        consume();

        // Bypass, mode 11; the result is then held under backpressure.
        held     = st4(32'h0f1e2d3c, 32'h4b5a6978, 32'h8796a5b4, 32'hc3d2e1f0);
        in_state = held;
        in_mode  = 2'b11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(n);
        chk("byp11_latency", 256'(n), 256'(4));
        chk("byp11_state", 256'(out_state), 256'(held));

        in_state = st4(32'hdb135345, 32'h2d26314c, 32'h01010101, 32'hdb135345);
        in_mode  = 2'b00;
        in_valid = 1'b1;
        repeat (10) tick();
        chk("bp_out_valid", 256'(out_valid), 256'(1'b1));
        chk("bp_out_state", 256'(out_state), 256'(held));
        chk("bp_in_ready",  256'(in_ready),  256'(1'b0));
        chk("bp_busy",      256'(busy),      256'(1'b0));
        out_ready = 1'b1;
        #1;
        chk("bp_ready_passthru", 256'(in_ready), 256'(1'b1));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_accepted",  256'(busy),      256'(1'b1));
        chk("bp_dropped",   256'(out_valid), 256'(1'b0));
        wait_done(n);
        chk("bp_latency", 256'(n), 256'(4));
        chk("bp_state", 256'(out_state),
            256'(st4(32'h8e4da1bc, 32'h4d7ebdf8, 32'h01010101, 32'h8e4da1bc)));

        // Parameter sweep, all started on the same edge.
        exp4     = st4(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8);
        sw4      = st4(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c);
        sw8      = {sw4, sw4};
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        l1 = 0; l2 = 0; l3 = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (v1 === 1'b1 && l1 == 0) l1 = k;
            if (v2 === 1'b1 && l2 == 0) l2 = k;
            if (v3 === 1'b1 && l3 == 0) l3 = k;
        end
        chk("sw_n4c2_latency", 256'(l1), 256'(2));
        chk("sw_n4c4_latency", 256'(l2), 256'(1));
        chk("sw_n8c4_latency", 256'(l3), 256'(2));
        chk("sw_n4c2_state", 256'(o1), 256'(exp4));
        chk("sw_n4c4_state", 256'(o2), 256'(exp4));
        chk("sw_n8c4_state", o3, {exp4, exp4});
        sw_ready = 1'b1;
        tick();
        sw_ready = 1'b0;

        // Asynchronous reset two cycles into a busy operation.
        consume();
        in_state = st4(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c);
        in_mode  = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_out_state", 256'(out_state), 256'(0));
        chk("arst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("arst_busy",      256'(busy),      256'(1'b0));
        #2;
        resetn = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(n);
        chk("post_rst_latency", 256'(n), 256'(4));
        chk("post_rst_state", 256'(out_state), 256'(exp4));
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_mixcolumns_iter.md
Name: mod_mixcolumns_iter

Overview:
- Parametrised, iterative MixColumns / InvMixColumns engine for the AES round datapath. One block serves both the encrypt and decrypt cores.
- Accepts a full state over a valid/ready handshake, then processes COLS_PER_CYCLE columns per clock. The result is held in an output register until the consumer takes it.
- A bypass mode provides the last-round pass-through, so the round controller keeps uniform timing.

Parameters:
- NB_COLS, 4, number of 32-bit state columns (Rijndael Nb); legal 4..8; state width = 32*NB_COLS bits.
- COLS_PER_CYCLE, 1, columns transformed per clock; must divide NB_COLS exactly; elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a state on in_state.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  [NB_COLS*4-1:0][7:0]  state bytes; byte index c*4+r = column c, row r.
- in_mode  input  2  00 forward MixColumns, 01 inverse, 10 bypass, 11 treated as bypass.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  consumer takes out_state this cycle.
- out_state  output  [NB_COLS*4-1:0][7:0]  result, same byte layout as in_state.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (async, resetn=0): state IDLE, column counter 0, working register 0, out_state 0, out_valid 0, busy 0. Any in-flight state is discarded. The first accept is possible on the first clk edge after resetn rises.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_state and in_mode, clear the counter, and go to BUSY.
- FSM BUSY:
  - in_ready=0, busy=1.
  - Each cycle, transform columns [cnt*CPC .. cnt*CPC+CPC-1] in the working register, then cnt += 1.
  - When the last group is written (cnt == NB_COLS/CPC-1), go to DONE.
- FSM DONE:
  - out_valid=1 and out_state stable.
  - On out_ready, drop out_valid and go to IDLE.
  - If in_valid is also high that cycle, accept the new state and go directly to BUSY.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- Latency: out_valid rises exactly NB_COLS/COLS_PER_CYCLE cycles after the accept edge. Bypass uses the same latency.
- Throughput: one state per NB_COLS/CPC+1 cycles when out_ready is held high.
- Forward transform, per column with rows a0..a3:
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- Inverse transform coefficients, row-rotated as above: 0e 0b 0d 09.
- Field arithmetic: GF(2^8) with polynomial 0x11b. xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits. 9x, 0bx, 0dx and 0ex are built from xtime chains; no multipliers and no lookup tables.
- Mode is latched at accept. Changing in_mode during BUSY has no effect.
- Counter wraps to 0 on exit from BUSY. No state is left over from a previous operation.
- out_state changes only on the transition into DONE and on reset. It is never driven from partial results: the working register is separate from out_state.
- in_valid while busy is ignored (not accepted). The producer must hold in_state until in_ready.
- out_ready while not out_valid has no effect.

Test Plan:
- Forward, NB_COLS=4, CPC=1, all columns db 13 53 45 -> every column 8e 4d a1 bc; out_valid exactly 4 cycles after accept.
- Inverse, same configuration, columns 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6 -> db135345, f20a225c, 01010101, d4d4d4d5.
- Bypass (in_mode=10 and 11) with arbitrary data -> out_state equals in_state; same 4-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid held and out_state stable, in_ready=0. Then raise out_ready with in_valid=1 -> new state accepted that same cycle; next result 4 cycles later.
- Parameter sweep:
  - CPC=2: latency 2.
  - CPC=4: latency 1.
  - NB_COLS=8 with CPC=4: latency 2.
  - Columns 2d26314c -> 4d7ebdf8 for every configuration.
- Reset mid-BUSY (resetn low at cycle 2) -> out_state=0, out_valid=0 and busy=0 immediately, without waiting for a clk edge. The next operation after release gives the correct result.
